// File: rtl/traffic_phase_ctrl_if.sv
// Front-end/driver bundle for the phase sequencer: controls and config in, lamps and display out.
interface traffic_phase_ctrl_if #(
  parameter int NUM_PHASES = 2,
  parameter int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
);
  logic                  enable;
  logic                  standby;
  logic                  skip;
  logic                  emerg_req;
  logic [PW-1:0]         emerg_phase;
  logic                  cfg_we;
  logic [PW-1:0]         cfg_phase;
  logic [1:0]            cfg_sel;
  logic [7:0]            cfg_bcd;
  logic                  cfg_err;
  logic [NUM_PHASES-1:0] lamp_r;
  logic [NUM_PHASES-1:0] lamp_y;
  logic [NUM_PHASES-1:0] lamp_g;
  logic [7:0]            cnt_bcd;
  logic                  cnt_valid;
  logic [PW-1:0]         active_phase;
  logic [2:0]            state;

  modport master (
    output enable, standby, skip, emerg_req, emerg_phase,
    output cfg_we, cfg_phase, cfg_sel, cfg_bcd,
    input  cfg_err, lamp_r, lamp_y, lamp_g, cnt_bcd, cnt_valid, active_phase, state
  );

  modport slave (
    input  enable, standby, skip, emerg_req, emerg_phase,
    input  cfg_we, cfg_phase, cfg_sel, cfg_bcd,
    output cfg_err, lamp_r, lamp_y, lamp_g, cnt_bcd, cnt_valid, active_phase, state
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic sequencer: GREEN -> YELLOW -> ALLRED per phase with BCD countdown,
// standby flash, skip and emergency preemption. All outputs come straight from registers.
module traffic_phase_ctrl #(
  parameter int         NUM_PHASES = 2,
  parameter int         TICK_DIV   = 50_000_000,
  parameter logic [7:0] DEF_GREEN  = 8'h25,
  parameter logic [7:0] DEF_YELLOW = 8'h04,
  parameter logic [7:0] DEF_ALLRED = 8'h02
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  traffic_phase_ctrl_if.slave bus
);
  localparam int PW    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_GREEN  = 3'd0,
    ST_YELLOW = 3'd1,
    ST_ALLRED = 3'd2,
    ST_STBY   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  state_e                     r_state, w_state_n;
  logic [PW-1:0]              r_phase, w_phase_n, w_phase_inc, w_ephase, w_green_ph;
  logic [7:0]                 r_cnt, w_cnt_n;
  logic [PRE_W-1:0]           r_pre, w_pre_n;
  logic                       r_skip, w_skip_n;
  logic                       r_flash, w_flash_n;
  logic                       r_valid, r_cfg_err;
  logic [NUM_PHASES-1:0]      r_lamp_r, r_lamp_y, r_lamp_g;
  logic [NUM_PHASES-1:0]      w_r_n, w_y_n, w_g_n, w_onehot;
  logic [NUM_PHASES-1:0][7:0] r_grn, r_yel, r_red;
  logic                       w_tick, w_cfg_ok;

  function automatic logic [7:0] f_ld(input logic [7:0] d);
    return (d == 8'h00) ? 8'h01 : d;
  endfunction

  function automatic logic [7:0] f_dec(input logic [7:0] d);
    return (d[3:0] == 4'h0) ? {d[7:4] - 4'h1, 4'h9} : {d[7:4], d[3:0] - 4'h1};
  endfunction

  assign w_tick      = bus.enable && (r_pre == '0);
  assign w_phase_inc = (r_phase == PW'(NUM_PHASES - 1)) ? '0 : r_phase + PW'(1);
  assign w_ephase    = (int'(bus.emerg_phase) < NUM_PHASES) ? bus.emerg_phase : '0;
  assign w_green_ph  = bus.emerg_req ? w_ephase : w_phase_inc;
  assign w_cfg_ok    = (bus.cfg_bcd[7:4] <= 4'd9) && (bus.cfg_bcd[3:0] <= 4'd9) &&
                       (bus.cfg_sel != 2'd3) && (int'(bus.cfg_phase) < NUM_PHASES);

  always_comb begin
    w_state_n = r_state;
    w_phase_n = r_phase;
    w_cnt_n   = r_cnt;
    w_pre_n   = r_pre;
    w_skip_n  = r_skip;
    w_flash_n = r_flash;
    if (bus.enable) begin
      w_pre_n = w_tick ? PRE_W'(TICK_DIV - 1) : r_pre - PRE_W'(1);
      if (bus.standby) begin
        w_skip_n = 1'b0;
        if (r_state != ST_STBY) begin
          w_state_n = ST_STBY;
          w_flash_n = 1'b1;
        end else if (w_tick) begin
          w_flash_n = ~r_flash;
        end
      end else if (r_state == ST_STBY) begin
        w_state_n = ST_ALLRED;
        w_cnt_n   = f_ld(r_red[r_phase]);
      end else if (r_state == ST_HOLD) begin
        // phase stays latched in r_phase while held, so later emerg_phase edits are ignored
        if (!bus.emerg_req) begin
          w_state_n = ST_GREEN;
          w_cnt_n   = f_ld(r_grn[r_phase]);
        end
      end else if (bus.emerg_req && r_state == ST_GREEN) begin
        w_skip_n = 1'b0;
        if (r_phase == w_ephase) begin
          w_state_n = ST_HOLD;
        end else begin
          w_state_n = ST_YELLOW;
          w_cnt_n   = f_ld(r_yel[r_phase]);
        end
      end else if (w_tick) begin
        w_skip_n = 1'b0;
        if (r_cnt > 8'h01 && !(r_skip || bus.skip)) begin
          w_cnt_n = f_dec(r_cnt);
        end else begin
          case (r_state)
            ST_GREEN: begin
              w_state_n = ST_YELLOW;
              w_cnt_n   = f_ld(r_yel[r_phase]);
            end
            ST_YELLOW: begin
              w_state_n = ST_ALLRED;
              w_cnt_n   = f_ld(r_red[r_phase]);
            end
            default: begin
              w_state_n = ST_GREEN;
              w_phase_n = w_green_ph;
              w_cnt_n   = f_ld(r_grn[w_green_ph]);
            end
          endcase
        end
      end else if (bus.skip) begin
        w_skip_n = 1'b1;
      end
    end
  end

  // Lamps decoded from next state so they land in registers alongside it.
  always_comb begin
    w_onehot = NUM_PHASES'(1) << w_phase_n;
    w_r_n    = '0;
    w_y_n    = '0;
    w_g_n    = '0;
    case (w_state_n)
      ST_GREEN, ST_HOLD: begin
        w_g_n = w_onehot;
        w_r_n = ~w_onehot;
      end
      ST_YELLOW: begin
        w_y_n = w_onehot;
        w_r_n = ~w_onehot;
      end
      ST_ALLRED: w_r_n = '1;
      default:   w_y_n = {NUM_PHASES{w_flash_n}};
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= ST_GREEN;
      r_phase   <= '0;
      r_cnt     <= DEF_GREEN;
      r_pre     <= PRE_W'(TICK_DIV - 1);
      r_skip    <= 1'b0;
      r_flash   <= 1'b0;
      r_valid   <= 1'b1;
      r_cfg_err <= 1'b0;
      r_lamp_g  <= NUM_PHASES'(1);
      r_lamp_r  <= ~NUM_PHASES'(1);
      r_lamp_y  <= '0;
      r_grn     <= {NUM_PHASES{DEF_GREEN}};
      r_yel     <= {NUM_PHASES{DEF_YELLOW}};
      r_red     <= {NUM_PHASES{DEF_ALLRED}};
    end else begin
      r_state   <= w_state_n;
      r_phase   <= w_phase_n;
      r_cnt     <= w_cnt_n;
      r_pre     <= w_pre_n;
      r_skip    <= w_skip_n;
      r_flash   <= w_flash_n;
      r_valid   <= !(w_state_n == ST_STBY || w_state_n == ST_HOLD);
      r_lamp_r  <= w_r_n;
      r_lamp_y  <= w_y_n;
      r_lamp_g  <= w_g_n;
      r_cfg_err <= bus.cfg_we && !w_cfg_ok;
      if (bus.cfg_we && w_cfg_ok) begin
        case (bus.cfg_sel)
          2'd0:    r_grn[bus.cfg_phase] <= bus.cfg_bcd;
          2'd1:    r_yel[bus.cfg_phase] <= bus.cfg_bcd;
          default: r_red[bus.cfg_phase] <= bus.cfg_bcd;
        endcase
      end
    end
  end

  assign bus.cfg_err      = r_cfg_err;
  assign bus.lamp_r       = r_lamp_r;
  assign bus.lamp_y       = r_lamp_y;
  assign bus.lamp_g       = r_lamp_g;
  assign bus.cnt_bcd      = r_cnt;
  assign bus.cnt_valid    = r_valid;
  assign bus.active_phase = r_phase;
  assign bus.state        = r_state;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl (2 phases, 4-cycle tick): integer-duration reference model
// checked every cycle, a config vector table, and directed multi-cycle sequences.
module tb_traffic_phase_ctrl;
  localparam int N  = 2;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  traffic_phase_ctrl_if #(.NUM_PHASES(N)) bus();

  traffic_phase_ctrl #(.NUM_PHASES(N), .TICK_DIV(TD)) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: whole-number tick counts, mode + segment index into a duration table.
  // mode 0 run, 1 standby, 2 emergency hold; seg 0 green, 1 yellow, 2 all-red.
  int m_mode, m_seg, m_ph, m_rem, m_div;
  int m_dur[3][N];
  bit m_flash, m_skip, m_err, m_init;

  typedef struct {
    logic       ph;
    logic [1:0] sel;
    logic [7:0] bcd;
    logic       err;
  } cfg_vec_t;
  cfg_vec_t vt[7];

  function automatic int ld(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic model_step();
    bit tk, sk, ok;
    int wv, eph;
    if (rst) begin
      m_mode = 0; m_seg = 0; m_ph = 0; m_rem = 25; m_div = TD - 1;
      m_flash = 0; m_skip = 0; m_err = 0; m_init = 1;
      for (int p = 0; p < N; p++) begin
        m_dur[0][p] = 25; m_dur[1][p] = 4; m_dur[2][p] = 2;
      end
      return;
    end
    ok = (bus.cfg_bcd[7:4] <= 9) && (bus.cfg_bcd[3:0] <= 9) && (bus.cfg_sel != 3) &&
         (int'(bus.cfg_phase) < N);
    wv = int'(bus.cfg_bcd[7:4]) * 10 + int'(bus.cfg_bcd[3:0]);
    eph = int'(bus.emerg_phase);
    if (bus.enable) begin
      tk = (m_div == 0);
      m_div = tk ? TD - 1 : m_div - 1;
      if (bus.standby) begin
        if (m_mode != 1) begin m_mode = 1; m_flash = 1; end
        else if (tk) m_flash = !m_flash;
        m_skip = 0;
      end else if (m_mode == 1) begin
        m_mode = 0; m_seg = 2; m_rem = ld(m_dur[2][m_ph]);
      end else if (m_mode == 2) begin
        if (!bus.emerg_req) begin m_mode = 0; m_seg = 0; m_rem = ld(m_dur[0][m_ph]); end
      end else if (bus.emerg_req && m_seg == 0) begin
        m_skip = 0;
        if (m_ph == eph) m_mode = 2;
        else begin m_seg = 1; m_rem = ld(m_dur[1][m_ph]); end
      end else if (tk) begin
        sk = m_skip || bus.skip;
        m_skip = 0;
        if (m_rem > 1 && !sk) m_rem--;
        else begin
          m_seg = (m_seg + 1) % 3;
          if (m_seg == 0) m_ph = bus.emerg_req ? eph : (m_ph + 1) % N;
          m_rem = ld(m_dur[m_seg][m_ph]);
        end
      end else if (bus.skip) m_skip = 1;
    end
    m_err = bus.cfg_we && !ok;
    if (bus.cfg_we && ok) m_dur[bus.cfg_sel][bus.cfg_phase] = wv;
  endtask

  function automatic logic [19:0] expv();
    logic [1:0] r, y, g, oh;
    logic [2:0] st;
    oh = 2'b01 << m_ph;
    r = '0; y = '0; g = '0;
    st = (m_mode == 1) ? 3'd3 : (m_mode == 2) ? 3'd4 : 3'(m_seg);
    if (m_mode == 1) y = {2{m_flash}};
    else if (m_mode == 2 || m_seg == 0) begin g = oh; r = ~oh; end
    else if (m_seg == 1) begin y = oh; r = ~oh; end
    else r = 2'b11;
    return {m_err, r, y, g, 4'(m_rem / 10), 4'(m_rem % 10), (m_mode == 0), 1'(m_ph), st};
  endfunction

  function automatic logic [19:0] actv();
    return {bus.cfg_err, bus.lamp_r, bus.lamp_y, bus.lamp_g, bus.cnt_bcd, bus.cnt_valid,
            bus.active_phase, bus.state};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_init) chk("model", 32'(actv()), 32'(expv()));
  endtask

  task automatic ticks(input int n);
    repeat (n * TD) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n;
    n = 0;
    while (bus.state !== s && n < 400) begin cyc(); n++; end
    chk(nm, 32'(bus.state), 32'(s));
  endtask

  initial begin
    vt[0] = '{1'b0, 2'd0, 8'h1A, 1'b1};
    vt[1] = '{1'b0, 2'd0, 8'hA1, 1'b1};
    vt[2] = '{1'b1, 2'd3, 8'h05, 1'b1};
    vt[3] = '{1'b0, 2'd1, 8'h9F, 1'b1};
    vt[4] = '{1'b0, 2'd0, 8'h09, 1'b0};
    vt[5] = '{1'b1, 2'd1, 8'h00, 1'b0};
    vt[6] = '{1'b1, 2'd2, 8'h03, 1'b0};
    bus.enable = 1'b1; bus.standby = 1'b0; bus.skip = 1'b0; bus.emerg_req = 1'b0;
    bus.emerg_phase = '0; bus.cfg_we = 1'b0; bus.cfg_phase = '0; bus.cfg_sel = '0;
    bus.cfg_bcd = '0;
    m_init = 0;
    @(negedge clk);

    // Reset values and a full ph0 interval sequence with BCD borrow points.
    do_reset();
    chk("rst_state", bus.state, 0);   chk("rst_cnt", bus.cnt_bcd, 8'h25);
    chk("rst_g", bus.lamp_g, 2'b01);  chk("rst_r", bus.lamp_r, 2'b10);
    chk("rst_y", bus.lamp_y, 2'b00);  chk("rst_valid", bus.cnt_valid, 1);
    chk("rst_phase", bus.active_phase, 0); chk("rst_err", bus.cfg_err, 0);
    ticks(5);  chk("bcd_20", bus.cnt_bcd, 8'h20);
    ticks(1);  chk("bcd_19", bus.cnt_bcd, 8'h19);
    ticks(9);  chk("bcd_10", bus.cnt_bcd, 8'h10);
    ticks(1);  chk("bcd_09", bus.cnt_bcd, 8'h09);
    ticks(8);  chk("green_01", bus.cnt_bcd, 8'h01); chk("green_st", bus.state, 0);
    ticks(1);  chk("yel_st", bus.state, 1); chk("yel_cnt", bus.cnt_bcd, 8'h04);
    chk("yel_y", bus.lamp_y, 2'b01); chk("yel_r", bus.lamp_r, 2'b10);
    ticks(4);  chk("ar_st", bus.state, 2); chk("ar_cnt", bus.cnt_bcd, 8'h02);
    chk("ar_r", bus.lamp_r, 2'b11);
    ticks(2);  chk("g1_st", bus.state, 0); chk("g1_ph", bus.active_phase, 1);
    chk("g1_cnt", bus.cnt_bcd, 8'h25); chk("g1_g", bus.lamp_g, 2'b10);

    // Skip latched mid-green, consumed on the following tick.
    do_reset();
    ticks(8); chk("skip_pre", bus.cnt_bcd, 8'h17);
    bus.skip = 1'b1; cyc(); bus.skip = 1'b0;
    cyc(); cyc(); chk("skip_wait", bus.cnt_bcd, 8'h17);
    cyc(); chk("skip_st", bus.state, 1); chk("skip_cnt", bus.cnt_bcd, 8'h04);
    chk("skip_ph", bus.active_phase, 0);

    // Emergency to the other phase, hold, ignore phase change, release.
    do_reset();
    ticks(3);
    bus.emerg_req = 1'b1; bus.emerg_phase = 1'b1;
    cyc(); chk("em_yel", bus.state, 1); chk("em_yel_cnt", bus.cnt_bcd, 8'h04);
    wait_state(3'd2, "em_ar"); chk("em_ar_cnt", bus.cnt_bcd, 8'h02);
    wait_state(3'd0, "em_g"); chk("em_g_ph", bus.active_phase, 1);
    cyc(); chk("em_hold", bus.state, 4); chk("em_valid", bus.cnt_valid, 0);
    chk("em_hold_g", bus.lamp_g, 2'b10); chk("em_hold_r", bus.lamp_r, 2'b01);
    bus.emerg_phase = 1'b0;
    ticks(2); chk("em_still", bus.state, 4); chk("em_still_ph", bus.active_phase, 1);
    bus.emerg_req = 1'b0;
    cyc(); chk("em_rel", bus.state, 0); chk("em_rel_cnt", bus.cnt_bcd, 8'h25);
    chk("em_rel_ph", bus.active_phase, 1);

    // Config table: rejects pulse cfg_err, accepted writes apply at next load.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.cfg_we = 1'b1; bus.cfg_phase = vt[i].ph; bus.cfg_sel = vt[i].sel;
      bus.cfg_bcd = vt[i].bcd;
      cyc(); bus.cfg_we = 1'b0;
      chk($sformatf("cfg_err%0d", i), bus.cfg_err, vt[i].err);
      cyc(); chk($sformatf("cfg_clr%0d", i), bus.cfg_err, 0);
    end
    chk("cfg_run", bus.state, 0);
    wait_state(3'd1, "cfg_y0"); chk("cfg_y0_cnt", bus.cnt_bcd, 8'h04);
    wait_state(3'd2, "cfg_a0"); chk("cfg_a0_cnt", bus.cnt_bcd, 8'h02);
    wait_state(3'd0, "cfg_g1"); chk("cfg_g1_cnt", bus.cnt_bcd, 8'h25);
    wait_state(3'd1, "cfg_y1"); chk("cfg_y1_cnt", bus.cnt_bcd, 8'h01);
    wait_state(3'd2, "cfg_a1"); chk("cfg_a1_cnt", bus.cnt_bcd, 8'h03);
    wait_state(3'd0, "cfg_g0"); chk("cfg_g0_cnt", bus.cnt_bcd, 8'h09);
    chk("cfg_g0_ph", bus.active_phase, 0);
    ticks(8); chk("cfg_g0_end", bus.cnt_bcd, 8'h01);
    ticks(1); chk("cfg_g0_y", bus.state, 1);

    // Standby mid-yellow: flash per tick, release through all-red.
    do_reset();
    wait_state(3'd1, "sb_y"); ticks(1);
    bus.standby = 1'b1;
    cyc(); chk("sb_st", bus.state, 3); chk("sb_y1", bus.lamp_y, 2'b11);
    chk("sb_r", bus.lamp_r, 0); chk("sb_g", bus.lamp_g, 0); chk("sb_valid", bus.cnt_valid, 0);
    begin
      int n;
      n = 0;
      while (bus.lamp_y !== 2'b00 && n < 2 * TD) begin cyc(); n++; end
      chk("sb_off", bus.lamp_y, 2'b00);
      n = 0;
      while (bus.lamp_y !== 2'b11 && n < 2 * TD) begin cyc(); n++; end
      chk("sb_on", bus.lamp_y, 2'b11); chk("sb_period", n, TD);
    end
    bus.standby = 1'b0;
    cyc(); chk("sb_ar", bus.state, 2); chk("sb_ar_cnt", bus.cnt_bcd, 8'h02);
    chk("sb_ar_r", bus.lamp_r, 2'b11);
    wait_state(3'd0, "sb_g"); chk("sb_g_ph", bus.active_phase, 1);
    chk("sb_g_cnt", bus.cnt_bcd, 8'h25);

    // Reset during emergency hold restores tables.
    do_reset();
    bus.cfg_we = 1'b1; bus.cfg_phase = 1'b0; bus.cfg_sel = 2'd1; bus.cfg_bcd = 8'h07;
    cyc(); bus.cfg_we = 1'b0;
    bus.emerg_req = 1'b1; bus.emerg_phase = 1'b0;
    cyc(); chk("rh_hold", bus.state, 4);
    ticks(1);
    rst = 1'b1; bus.emerg_req = 1'b0;
    cyc(); rst = 1'b0;
    chk("rh_st", bus.state, 0); chk("rh_cnt", bus.cnt_bcd, 8'h25);
    chk("rh_ph", bus.active_phase, 0);
    wait_state(3'd1, "rh_y"); chk("rh_y_cnt", bus.cnt_bcd, 8'h04);

    // Randomized traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      bus.enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 199) == 0) bus.standby = ~bus.standby;
      if ($urandom_range(0, 149) == 0) bus.emerg_req = ~bus.emerg_req;
      if ($urandom_range(0, 49) == 0) bus.emerg_phase = 1'($urandom);
      bus.skip = ($urandom_range(0, 29) == 0);
      bus.cfg_we = ($urandom_range(0, 15) == 0);
      bus.cfg_phase = 1'($urandom);
      bus.cfg_sel = 2'($urandom);
      bus.cfg_bcd = ($urandom_range(0, 5) == 0) ? 8'($urandom) :
                    {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      rst = ($urandom_range(0, 999) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
